// File: rtl/regfile_pkg.sv
// Shared state type and elaboration-time helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 32'sd2) && ((value & (value - 32'sd1)) == 32'sd0);
  endfunction

  function automatic bit params_legal(input int depth, input int num_read);
    return is_pow2(depth) && (num_read >= 32'sd1) && (num_read <= 32'sd4);
  endfunction

endpackage

// File: rtl/regfile_bank.sv
// One memory copy: single write port, single registered read port, with
// optional hardwired-zero register and write-first bypass.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int ADDR_W   = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              hold_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] raw_q;
  logic [WIDTH-1:0] byp_data_q;
  logic             byp_q;
  logic             zero_q;
  logic             wr_en_s;
  logic             byp_d;
  logic             zero_d;

  // Writes to the hardwired-zero register never reach the array.
  always_comb begin
    wr_en_s = we_i && !((ZERO_REG != 0) && (waddr_i == '0));
    zero_d  = (ZERO_REG != 0) && (raddr_i == '0);
    byp_d   = (BYPASS != 0) && wr_en_s && (waddr_i == raddr_i);
  end

  // Plain array with read-before-write semantics, kept reset-free so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[waddr_i] <= wdata_i;
    end
    raw_q <= mem_q[raddr_i];
  end

  // Output selection flags; hold forces the port to read as zero.
  always_ff @(posedge clk) begin
    if (hold_i) begin
      zero_q     <= 1'b1;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      zero_q     <= zero_d;
      byp_q      <= byp_d;
      byp_data_q <= wdata_i;
    end
  end

  assign rdata_o = zero_q ? '0 : (byp_q ? byp_data_q : raw_q);

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: NUM_READ operand ports plus a debug port, each
// served by its own memory copy, with a post-reset clear sequencer.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 32,
  parameter int NUM_READ       = 2,
  parameter int ZERO_REG       = 1,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ADDR_W        = clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         write,
  input  logic [ADDR_W-1:0]            wrAddr,
  input  logic [WIDTH-1:0]             wrData,
  input  logic [NUM_READ*ADDR_W-1:0]   rdAddr,
  output logic [NUM_READ*WIDTH-1:0]    rdData,
  input  logic [ADDR_W-1:0]            dbgAddr,
  output logic [WIDTH-1:0]             dbgData,
  output logic                         ready
);

  if (!params_legal(DEPTH, NUM_READ)) begin : g_illegal_params
    $error("regfile_multiport: DEPTH must be a power of two >= 2 and NUM_READ in 1..4");
  end

  rf_state_e         state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              ready_q;
  logic              hold_s;
  logic              bank_we_s;
  logic [ADDR_W-1:0] bank_waddr_s;
  logic [WIDTH-1:0]  bank_wdata_s;

  // Shared write port: the clear sequencer owns it until the file is ready.
  always_comb begin
    hold_s = reset || (state_q != READY);
    if (reset) begin
      bank_we_s    = 1'b0;
      bank_waddr_s = wrAddr;
      bank_wdata_s = '0;
    end else if (state_q == CLEAR) begin
      bank_we_s    = (CLEAR_ON_RESET != 0);
      bank_waddr_s = clr_addr_q;
      bank_wdata_s = '0;
    end else begin
      bank_we_s    = write;
      bank_waddr_s = wrAddr;
      bank_wdata_s = wrData;
    end
  end

  // Clear/ready sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if ((CLEAR_ON_RESET == 0) || (clr_addr_q == ADDR_W'(DEPTH - 1))) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end else begin
            clr_addr_q <= clr_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            ready_q    <= 1'b0;
          end
        end
        READY: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q    <= CLEAR;
          clr_addr_q <= '0;
          ready_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;

  // Copy NUM_READ is the debug copy; all copies see the same write.
  for (genvar i = 0; i <= NUM_READ; i++) begin : g_bank
    logic [ADDR_W-1:0] raddr_s;
    logic [WIDTH-1:0]  rdata_s;

    if (i < NUM_READ) begin : g_operand
      assign raddr_s                      = rdAddr[i*ADDR_W +: ADDR_W];
      assign rdData[i*WIDTH +: WIDTH]     = rdata_s;
    end else begin : g_debug
      assign raddr_s = dbgAddr;
      assign dbgData = rdata_s;
    end

    regfile_bank #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS),
      .ADDR_W   (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .hold_i  (hold_s),
      .we_i    (bank_we_s),
      .waddr_i (bank_waddr_s),
      .wdata_i (bank_wdata_s),
      .raddr_i (raddr_s),
      .rdata_o (rdata_s)
    );
  end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised general-purpose register file for the RV32 core. It is built from inferred synchronous-read memories that map to iCE40 EBR, with one memory copy per read port.
- Generalises the fixed 32x32, 2-read-port file to configurable width, depth and read-port count.
- Adds a hardwired-zero register, optional write-to-read bypass, and a debug/LED read port.
- Adds a reset-time clear sequencer with a ready flag, because EBR contents are not reset.

Parameters:
WIDTH, 32, data bits per register
DEPTH, 32, number of registers; power of two, >= 2; ADDR_W = clog2(DEPTH)
NUM_READ, 2, number of operand read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
BYPASS, 1, 1 = write-first on same-cycle address match; 0 = read-first (old data)
CLEAR_ON_RESET, 1, 1 = zero every register after reset via sequencer

Ports:
clk  in  1  single clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
write  in  1  write enable
wrAddr  in  ADDR_W  write address
wrData  in  WIDTH  write data
rdAddr  in  NUM_READ*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
rdData  out  NUM_READ*WIDTH  packed read data; port i at [i*WIDTH +: WIDTH]
dbgAddr  in  ADDR_W  debug/LED read address
dbgData  out  WIDTH  debug read data
ready  out  1  high when the file accepts writes and returns valid data

Behaviour:
- Reset values: rdData = 0, dbgData = 0, ready = 0. If CLEAR_ON_RESET = 0, ready = 1 on the first edge with reset low.
- FSM states: CLEAR, READY.
  - While reset is high: state = CLEAR, clrAddr = 0.
  - In CLEAR with reset low: each edge writes 0 to clrAddr in all copies, then clrAddr++.
  - On the edge that clears DEPTH-1: go to READY.
  - ready is registered, so ready = 1 exactly DEPTH edges after reset release.
- Reset asserted at any point (mid-CLEAR or in READY) restarts CLEAR from address 0. In-flight reads are discarded and outputs return to 0.
- During CLEAR:
  - External write is ignored.
  - rdData and dbgData are held at 0.
- Write (READY state only):
  - Takes effect on the edge where write = 1, into all NUM_READ+1 copies simultaneously.
  - If ZERO_REG = 1 and wrAddr = 0, the write is dropped.
- Read latency: address sampled at edge N; data visible on rdData/dbgData after edge N until edge N+1. Exactly 1 cycle, registered.
- Same-edge match (write = 1, wrAddr = rdAddr[i], write not dropped):
  - BYPASS = 1: port i returns wrData.
  - BYPASS = 0: port i returns the pre-write contents.
  - The same rule applies to the debug port.
- ZERO_REG = 1: a read of address 0 returns 0 regardless of memory contents or bypass.
- Read ports are fully independent; all ports may read the same address in the same cycle.
- Addresses are exactly ADDR_W bits, so there is no out-of-range case.
- No combinational path from any input to any output.

Decomposition:
- Package regfile_pkg holds:
  - state enum {CLEAR, READY};
  - clog2 helper function;
  - parameter-legality checks (DEPTH power of two, 1 <= NUM_READ <= 4).
- Sub-module regfile_bank: one DEPTH x WIDTH memory with 1 write port and 1 synchronous read port, plus BYPASS and ZERO_REG handling. It is instantiated NUM_READ+1 times in a generate loop.
- The top level holds the FSM, clrAddr counter, write-mux (clear vs external) and ready register.

Test Plan:
1. Reset held 3 cycles, then released with defaults -> ready = 0 for 32 edges, ready = 1 at edge 32; afterwards a read of every address on all ports returns 0x00000000.
2. Write x5 = 0xDEADBEEF, next cycle rdAddr0 = 5, rdAddr1 = 5, dbgAddr = 5 -> all three read 0xDEADBEEF one cycle later.
3. Same edge: write x7 = 0x12345678 while rdAddr0 = 7 and x7 previously held 0xAAAA5555 -> rdData0 = 0x12345678 with BYPASS = 1, and 0xAAAA5555 with BYPASS = 0.
4. Write x0 = 0xFFFFFFFF, then read x0 on all ports, including a same-edge read -> 0x00000000 everywhere.
5. Write x3 = 0x1, reassert reset at clear count 10, release -> ready stays 0 for a further 32 edges; x3 then reads 0; a write attempted during CLEAR has no effect.
6. WIDTH = 16, DEPTH = 64, NUM_READ = 3: write x63 = 0xBEEF and x1 = 0x0001, then read ports 0/1/2 = 63/1/63 -> 0xBEEF/0x0001/0xBEEF.
